uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serialises parallel words onto a UART line: 1 start bit, DATA_WIDTH data bits (LSB first),
//   optional parity, 1 or 2 stop bits. Transmit end of the UART link, paired with the receiver
//   block. Upstream hands in one word per frame through a valid/ready handshake. Output is
//   registered and glitch-free.
// PARAMETERS
//   DATA_WIDTH  8           data bits per frame
//   BAUD_RATE   9600        output bit rate, bits/s
//   CLK_FREQ    12_000_000  clk frequency, Hz; PULSE_WIDTH = CLK_FREQ/BAUD_RATE clocks per bit
//   PARITY      0           0 = none, 1 = even, 2 = odd
//   STOP_BITS   1           number of stop bits, 1 or 2
// PORTS
//   clk    in   1           clock, rising edge
//   rst    in   1           synchronous reset, active-high
//   data   in   DATA_WIDTH  word to send; sampled only at handshake
//   valid  in   1           upstream word available; must be held with data stable until accepted
//   ready  out  1           transmitter idle; handshake = valid && ready at a rising clk edge
//   sig    out  1           serial line, idle high
//   busy   out  1           high from handshake until the last stop bit has finished
// BEHAVIOUR
//   Reset and startup
//   - Reset (rst high at an edge): sig=1, ready=0, busy=0, state IDLE, counters cleared.
//   - ready rises at the first edge with rst low.
//   State machine: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE
//   - IDLE: ready=1, sig=1. On handshake at edge E0: latch data into shift reg, ready<=0,
//     busy<=1, sig<=0, enter START.
//   - Every bit lasts exactly PULSE_WIDTH cycles. A down-counter reloads to PULSE_WIDTH-1 on
//     each bit boundary.
//   - DATA: sends shift reg LSB first; a bit counter runs 0..DATA_WIDTH-1.
//   - PARITY: bit = ^data (even) or ~^data (odd), computed on the latched word.
//   - STOP: sig=1 for STOP_BITS*PULSE_WIDTH cycles. At edge E0 + N*PULSE_WIDTH return to IDLE
//     with ready<=1, busy<=0. N = 1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS.
//   Timing
//   - Latency: sig falls at E0, the same edge that accepts the word.
//   - Minimum handshake spacing is N*PULSE_WIDTH+1 cycles, i.e. exactly one extra idle-high
//     clock between back-to-back frames.
//   Boundary conditions
//   - valid while ready=0: ignored; data changes while not ready have no effect.
//   - valid deasserted before ready rises: no frame is sent.
//   - Reset mid-frame: the frame is aborted. sig=1 from the reset edge, the latched word is
//     discarded, and no further low bits are emitted.
//   - Widths: bit counter is $clog2(DATA_WIDTH)+1 bits; baud counter is
//     $clog2(PULSE_WIDTH)+1 bits; no wrap occurs within a bit.
//   - Elaboration $error if any of these fails: PULSE_WIDTH>=2, PARITY in 0..2,
//     STOP_BITS in 1..2, DATA_WIDTH>=1.
// TESTING  (CLK_FREQ=160, BAUD_RATE=10 -> PULSE_WIDTH=16 unless noted)
//   1. 0x55, PARITY=0, STOP_BITS=1, handshake at E0 -> sig: 0 for 16 clocks, then
//      1,0,1,0,1,0,1,0 each 16 clocks, then stop high 16 clocks; ready=1 at E0+160.
//   2. 0xA5 then 0x3C, valid held continuously -> second start bit falls at E0+161; exactly one
//      idle-high clock between frames; both frames bit-exact.
//   3. 0x07, PARITY=1 -> parity bit 1; PARITY=2 -> parity bit 0; ready at E0+176 in both cases.
//   4. 0x80, STOP_BITS=2, PARITY=0 -> stop high 32 clocks; ready at E0+176;
//      a valid pulse held during the frame is not accepted until then.
//   5. rst asserted in data bit 3 of 0x00 -> sig=1 from that edge; ready=0 while rst=1;
//      ready=1 one edge after release; no low on sig until a new handshake.
//   6. Loopback into the receiver (same parameters, DATA_WIDTH=8): 256 random bytes with random
//      valid gaps -> all received equal and in order, no framing loss.

Source files
------------

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Accepts one parallel word per frame through
//               a valid/ready handshake and serialises it as start bit, data
//               bits LSB first, optional parity bit and one or two stop bits.
//               The serial line is driven directly from a flop (glitch-free).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 9600,
   parameter int CLK_FREQ   = 12_000_000,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  valid,
   output logic                  ready,
   output logic                  sig,
   output logic                  busy
);

   localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
   localparam int BAUD_W      = $clog2(PULSE_WIDTH) + 1;
   localparam int BIT_W       = $clog2(DATA_WIDTH) + 1;

   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(PULSE_WIDTH - 1);
   localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);

   // Parameter sanity checks, evaluated at elaboration time
   if (PULSE_WIDTH < 2) begin : g_chk_pulse
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (DATA_WIDTH < 1) begin : g_chk_width
      $error("uart_tx: DATA_WIDTH must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [BAUD_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shifted;
   logic                  par_bit;
   logic                  sig_next;
   logic                  handshake;
   logic                  bit_end;
   logic                  shift;
   logic                  cnt_clr;
   logic                  cnt_inc;
   logic                  frame_done;

   // State register; reset aborts any frame in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and next value of the serial line
   always_comb begin
      state_next = state;
      sig_next   = sig;
      handshake  = 1'b0;
      shift      = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      frame_done = 1'b0;
      bit_end    = (baud_cnt == '0);
      shifted    = shreg >> 1;
      case (state)
         S_IDLE: begin
            sig_next = 1'b1;
            if (valid && ready) begin
               handshake  = 1'b1;
               sig_next   = 1'b0;
               state_next = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_next = S_DATA;
               sig_next   = shreg[0];
               cnt_clr    = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_DATA) begin
                  cnt_clr = 1'b1;
                  if (PARITY != 0) begin
                     state_next = S_PARITY;
                     sig_next   = par_bit;
                  end else begin
                     state_next = S_STOP;
                     sig_next   = 1'b1;
                  end
               end else begin
                  // next data bit is the one after the current LSB
                  cnt_inc  = 1'b1;
                  shift    = 1'b1;
                  sig_next = shifted[0];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_next = S_STOP;
               sig_next   = 1'b1;
               cnt_clr    = 1'b1;
            end
         end
         S_STOP: begin
            sig_next = 1'b1;
            if (bit_end) begin
               if (bit_cnt == LAST_STOP) begin
                  state_next = S_IDLE;
                  frame_done = 1'b1;
                  cnt_clr    = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            sig_next   = 1'b1;
         end
      endcase
   end

   // Serial line flop: idle high, forced high by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= 1'b1;
      end else begin
         sig <= sig_next;
      end
   end

   // Baud down-counter: reloads on every bit boundary, free of wrap within a bit
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt <= '0;
      end else if (handshake) begin
         baud_cnt <= BAUD_RELOAD;
      end else if (state != S_IDLE) begin
         baud_cnt <= bit_end ? BAUD_RELOAD : baud_cnt - 1'b1;
      end
   end

   // Bit counter shared by the data bits and the stop bits
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
      end else if (handshake || cnt_clr) begin
         bit_cnt <= '0;
      end else if (cnt_inc) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // Shift register and parity captured from the word accepted at handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         par_bit <= 1'b0;
      end else if (handshake) begin
         shreg   <= data;
         par_bit <= (PARITY == 2) ? ~^data : ^data;
      end else if (shift) begin
         shreg <= shifted;
      end
   end

   // Handshake flags: ready only in idle, busy for the whole frame
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b0;
         busy  <= 1'b0;
      end else if (handshake) begin
         ready <= 1'b0;
         busy  <= 1'b1;
      end else if (frame_done) begin
         ready <= 1'b1;
         busy  <= 1'b0;
      end else if (state == S_IDLE) begin
         ready <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Four transmitters with
//               different parity / stop-bit settings share clock and reset.
//               A serial decoder on instance 0 pops expected bytes from a
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   localparam int PW = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid [4];
   logic [7:0] din   [4];
   logic       ready [4];
   logic       sig   [4];
   logic       busy  [4];

   int total = 0;
   int bad   = 0;
   int rx_count = 0;
   bit mon_en = 1'b0;
   logic [7:0] sb_q [$];

   typedef struct {
      int         idx;
      logic [7:0] d;
      int         len;
      int         par_bit;
   } vec_t;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(10), .CLK_FREQ(160), .PARITY(0), .STOP_BITS(1)) u_p0s1 (
      .clk(clk), .rst(rst), .data(din[0]), .valid(valid[0]),
      .ready(ready[0]), .sig(sig[0]), .busy(busy[0]));
   uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(10), .CLK_FREQ(160), .PARITY(1), .STOP_BITS(1)) u_p1s1 (
      .clk(clk), .rst(rst), .data(din[1]), .valid(valid[1]),
      .ready(ready[1]), .sig(sig[1]), .busy(busy[1]));
   uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(10), .CLK_FREQ(160), .PARITY(2), .STOP_BITS(1)) u_p2s1 (
      .clk(clk), .rst(rst), .data(din[2]), .valid(valid[2]),
      .ready(ready[2]), .sig(sig[2]), .busy(busy[2]));
   uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(10), .CLK_FREQ(160), .PARITY(0), .STOP_BITS(2)) u_p0s2 (
      .clk(clk), .rst(rst), .data(din[3]), .valid(valid[3]),
      .ready(ready[3]), .sig(sig[3]), .busy(busy[3]));

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge where ready is seen high
   task automatic wait_ready(input int idx);
      int n = 0;
      while (ready[idx] !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk($sformatf("ready_timeout%0d", idx), 0, 1);
   endtask

   // Called just after the accepting edge E0; checks every clock of the frame,
   // then the state right after edge E0+len
   task automatic check_frame(input int idx, input logic [7:0] d, input int len, input int par_bit);
      int nbits = len / PW;
      int expv;
      int errs;
      for (int j = 0; j < nbits; j++) begin
         if (j == 0)                          expv = 0;
         else if (j <= 8)                     expv = int'(d[j-1]);
         else if (par_bit >= 0 && j == 9)     expv = par_bit;
         else                                 expv = 1;
         errs = 0;
         for (int c = 0; c < PW; c++) begin
            @(negedge clk);
            if (sig[idx] !== expv[0] || ready[idx] !== 1'b0 || busy[idx] !== 1'b1) errs++;
            @(posedge clk);
         end
         chk($sformatf("frame%0d_%02h_bit%0d_badclocks", idx, d, j), errs, 0);
      end
      @(negedge clk);
      chk($sformatf("end%0d_ready", idx), int'(ready[idx]), 1);
      chk($sformatf("end%0d_busy", idx), int'(busy[idx]), 0);
      chk($sformatf("end%0d_sig", idx), int'(sig[idx]), 1);
   endtask

   task automatic send(input int idx, input logic [7:0] d, input int len, input int par_bit);
      wait_ready(idx);
      valid[idx] = 1'b1;
      din[idx]   = d;
      if (idx == 0 && mon_en) sb_q.push_back(d);
      @(posedge clk);
      #1 valid[idx] = 1'b0;
      check_frame(idx, d, len, par_bit);
   endtask

   // Mid-bit sampling decoder on instance 0
   task automatic rx_frame();
      logic [7:0] b;
      logic [7:0] expb;
      repeat (7) @(negedge clk);
      chk("rx_start_low", int'(sig[0]), 0);
      for (int i = 0; i < 8; i++) begin
         repeat (PW) @(negedge clk);
         b[i] = sig[0];
      end
      repeat (PW) @(negedge clk);
      chk("rx_stop_high", int'(sig[0]), 1);
      rx_count++;
      if (sb_q.size() == 0) begin
         chk("rx_unexpected_byte", int'(b), -1);
      end else begin
         expb = sb_q.pop_front();
         chk("rx_byte", int'(b), int'(expb));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && sig[0] === 1'b0) rx_frame();
      end
   end

   initial begin
      vec_t vecs [8];
      int   n;
      int   lows;
      int   rx_base;
      logic [7:0] rd;

      vecs[0] = '{idx: 0, d: 8'h55, len: 160, par_bit: -1};
      vecs[1] = '{idx: 1, d: 8'h07, len: 176, par_bit: 1};
      vecs[2] = '{idx: 2, d: 8'h07, len: 176, par_bit: 0};
      vecs[3] = '{idx: 1, d: 8'h00, len: 176, par_bit: 0};
      vecs[4] = '{idx: 2, d: 8'h00, len: 176, par_bit: 1};
      vecs[5] = '{idx: 0, d: 8'hFF, len: 160, par_bit: -1};
      vecs[6] = '{idx: 3, d: 8'h80, len: 176, par_bit: -1};
      vecs[7] = '{idx: 1, d: 8'h80, len: 176, par_bit: 1};

      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid[i] = 1'b0;
         din[i]   = 8'h00;
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst%0d_sig", i), int'(sig[i]), 1);
         chk($sformatf("rst%0d_ready", i), int'(ready[i]), 0);
         chk($sformatf("rst%0d_busy", i), int'(busy[i]), 0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("first_ready%0d", i), int'(ready[i]), 1);

      // table-driven single frames
      mon_en = 1'b1;
      for (int v = 0; v < 8; v++) send(vecs[v].idx, vecs[v].d, vecs[v].len, vecs[v].par_bit);

      // back-to-back with valid held: one idle clock, second start at E0+161
      wait_ready(0);
      valid[0] = 1'b1;
      din[0]   = 8'hA5;
      sb_q.push_back(8'hA5);
      @(posedge clk);
      #1 din[0] = 8'h3C;
      sb_q.push_back(8'h3C);
      check_frame(0, 8'hA5, 160, -1);
      @(posedge clk);
      #1 valid[0] = 1'b0;
      check_frame(0, 8'h3C, 160, -1);

      // two stop bits; valid raised mid-frame must wait for ready
      wait_ready(3);
      valid[3] = 1'b1;
      din[3]   = 8'h80;
      @(posedge clk);
      #1 valid[3] = 1'b0;
      fork
         check_frame(3, 8'h80, 176, -1);
         begin
            repeat (50) @(negedge clk);
            valid[3] = 1'b1;
            din[3]   = 8'hFF;
         end
      join
      @(posedge clk);
      #1 valid[3] = 1'b0;
      check_frame(3, 8'hFF, 176, -1);

      // reset during data bit 3 of 0x00
      n = 0;
      while (sb_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain_before_reset", sb_q.size(), 0);
      repeat (20) @(negedge clk);
      mon_en = 1'b0;
      wait_ready(0);
      valid[0] = 1'b1;
      din[0]   = 8'h00;
      @(posedge clk);
      #1 valid[0] = 1'b0;
      repeat (70) @(negedge clk);
      chk("pre_reset_bit3_low", int'(sig[0]), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sig", int'(sig[0]), 1);
      chk("midrst_ready", int'(ready[0]), 0);
      chk("midrst_busy", int'(busy[0]), 0);
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (ready[0] !== 1'b0 || sig[0] !== 1'b1) n++;
      end
      chk("held_rst_badclocks", n, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", int'(ready[0]), 1);
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (sig[0] !== 1'b1) lows++;
      end
      chk("post_rst_no_low_clocks", lows, 0);

      // loopback: random bytes, random idle gaps
      mon_en  = 1'b1;
      rx_base = rx_count;
      for (int k = 0; k < 256; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         wait_ready(0);
         rd = 8'($urandom);
         valid[0] = 1'b1;
         din[0]   = rd;
         sb_q.push_back(rd);
         @(posedge clk);
         #1 valid[0] = 1'b0;
         @(negedge clk);
      end
      n = 0;
      while (sb_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("loopback_queue_left", sb_q.size(), 0);
      chk("loopback_rx_count", rx_count - rx_base, 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
